// File: rtl/trail_painter.sv
// Trail painter: per frame, probes each player's anchor pixel for an existing trail,
// then paints a BLK x BLK block in the player's colour through the framebuffer arbiter.
module trail_painter #(
    parameter int unsigned NUM_PLAYERS = 2,
    parameter int unsigned COORD_W     = 8,
    parameter int unsigned ADDR_W      = 20,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned BLK         = 2,
    parameter int unsigned PITCH       = 320,
    parameter int unsigned X_OFF       = 8,
    parameter int unsigned RD_LAT      = 2,
    parameter logic [2:0]  PLAY_STATE  = 3'b010
) (
    input  logic                           Clk,
    input  logic                           Reset_n,
    input  logic                           frame_clk,
    input  logic [2:0]                     Game_State,
    input  logic [NUM_PLAYERS*COORD_W-1:0] pos_x,
    input  logic [NUM_PLAYERS*COORD_W-1:0] pos_y,
    input  logic [NUM_PLAYERS*DATA_W-1:0]  color,
    output logic [ADDR_W-1:0]              fb_addr,
    output logic [DATA_W-1:0]              fb_wdata,
    output logic                           fb_we,
    output logic                           fb_re,
    input  logic                           fb_ready,
    input  logic [DATA_W-1:0]              fb_rdata,
    output logic [NUM_PLAYERS-1:0]         collision,
    output logic                           busy,
    output logic                           done
);

    localparam int unsigned PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
    localparam int unsigned LW = $clog2(RD_LAT + 1);
    localparam logic [1:0] BLK_LAST = 2'(BLK - 1);
    localparam logic [PW-1:0] P_LAST = PW'(NUM_PLAYERS - 1);
    localparam logic [LW-1:0] WAIT_LAST = LW'(RD_LAT - 1);

    typedef enum logic [2:0] {
        StIdle, StLatch, StRead, StWait, StWrite, StNext, StDone
    } state_e;

    state_e state_q, state_d;

    logic frame_q, frame_d1_q, rise;
    logic in_play, in_play_q, enter_play;
    logic pending_q;
    logic [PW-1:0] p_q, p_next;
    logic [1:0] row_q, col_q;
    logic [LW-1:0] wait_q;
    logic last_beat, last_p, start_req, wait_done;

    logic [COORD_W-1:0] x_q [NUM_PLAYERS];
    logic [COORD_W-1:0] y_q [NUM_PLAYERS];
    logic [DATA_W-1:0]  color_q [NUM_PLAYERS];
    logic [COORD_W-1:0] prev_x_q [NUM_PLAYERS];
    logic [COORD_W-1:0] prev_y_q [NUM_PLAYERS];
    logic prev_valid_q;
    logic [NUM_PLAYERS-1:0] skip_now, skip_q, collision_q;

    logic [ADDR_W-1:0] anchor, blk_off;

    assign rise       = frame_q & ~frame_d1_q;
    assign in_play    = (Game_State == PLAY_STATE);
    assign enter_play = in_play & ~in_play_q;
    assign start_req  = rise | pending_q;
    assign last_beat  = (row_q == BLK_LAST) && (col_q == BLK_LAST);
    assign last_p     = (p_q == P_LAST);
    assign p_next     = p_q + 1'b1;
    assign wait_done  = (wait_q == WAIT_LAST);

    // An unmoved player would otherwise collide with its own head.
    always_comb begin
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            skip_now[i] = prev_valid_q &&
                          (pos_x[i*COORD_W +: COORD_W] == prev_x_q[i]) &&
                          (pos_y[i*COORD_W +: COORD_W] == prev_y_q[i]);
        end
    end

    always_comb begin
        anchor  = (ADDR_W'(x_q[p_q]) + ADDR_W'(X_OFF)) * ADDR_W'(BLK) +
                  ADDR_W'(y_q[p_q]) * ADDR_W'(PITCH * BLK);
        blk_off = ADDR_W'(row_q) * ADDR_W'(PITCH) + ADDR_W'(col_q);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_req) state_d = StLatch;
            StLatch: state_d = skip_now[0] ? StWrite : StRead;
            StRead:  if (fb_ready) state_d = StWait;
            StWait:  if (wait_done) state_d = StWrite;
            StWrite: begin
                if (fb_ready && last_beat) begin
                    if (last_p) begin
                        state_d = StNext;
                    end else begin
                        state_d = skip_q[p_next] ? StWrite : StRead;
                    end
                end
            end
            StNext:  state_d = StDone;
            StDone:  state_d = start_req ? StLatch : StIdle;
            default: state_d = StIdle;
        endcase
        if (!in_play) state_d = StIdle;
    end

    always_comb begin
        fb_re    = 1'b0;
        fb_we    = 1'b0;
        fb_addr  = '0;
        fb_wdata = '0;
        unique case (state_q)
            StRead: begin
                fb_re   = 1'b1;
                fb_addr = anchor;
            end
            StWrite: begin
                fb_we    = 1'b1;
                fb_addr  = anchor + blk_off;
                fb_wdata = color_q[p_q];
            end
            default: ;
        endcase
        busy = (state_q != StIdle);
        done = (state_q == StDone);
    end

    assign collision = collision_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            frame_q      <= 1'b0;
            frame_d1_q   <= 1'b0;
            in_play_q    <= 1'b0;
            pending_q    <= 1'b0;
            p_q          <= '0;
            row_q        <= '0;
            col_q        <= '0;
            wait_q       <= '0;
            prev_valid_q <= 1'b0;
            skip_q       <= '0;
            collision_q  <= '0;
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                x_q[i]      <= '0;
                y_q[i]      <= '0;
                color_q[i]  <= '0;
                prev_x_q[i] <= '0;
                prev_y_q[i] <= '0;
            end
        end else begin
            frame_q    <= frame_clk;
            frame_d1_q <= frame_q;
            in_play_q  <= in_play;

            // Only one queued pass; a start consumes it.
            if (!in_play || state_d == StLatch) begin
                pending_q <= 1'b0;
            end else if (rise && state_q != StIdle) begin
                pending_q <= 1'b1;
            end

            if (state_q == StLatch) begin
                for (int i = 0; i < NUM_PLAYERS; i++) begin
                    x_q[i]     <= pos_x[i*COORD_W +: COORD_W];
                    y_q[i]     <= pos_y[i*COORD_W +: COORD_W];
                    color_q[i] <= color[i*DATA_W +: DATA_W];
                end
                skip_q <= skip_now;
                p_q    <= '0;
                row_q  <= '0;
                col_q  <= '0;
            end

            if (state_q == StRead && fb_ready) wait_q <= '0;
            if (state_q == StWait) wait_q <= wait_q + 1'b1;

            if (state_q == StWrite && fb_ready) begin
                if (last_beat) begin
                    row_q <= '0;
                    col_q <= '0;
                    if (!last_p) p_q <= p_next;
                end else if (col_q == BLK_LAST) begin
                    col_q <= '0;
                    row_q <= row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end

            if (enter_play) begin
                collision_q <= '0;
            end else if (in_play && state_q == StWait && wait_done && fb_rdata != '0) begin
                collision_q[p_q] <= 1'b1;
            end

            if (!in_play) begin
                prev_valid_q <= 1'b0;
            end else if (state_q == StDone) begin
                prev_valid_q <= 1'b1;
                for (int i = 0; i < NUM_PLAYERS; i++) begin
                    prev_x_q[i] <= x_q[i];
                    prev_y_q[i] <= y_q[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_trail_painter.sv
// Directed bench for trail_painter: table of frame passes plus pending-tick and abort sequences.
module tb_trail_painter;

    localparam int unsigned RD_LAT = 2;
    localparam logic [2:0] PLAY = 3'b010;
    localparam logic [15:0] C0 = 16'hF800;
    localparam logic [15:0] C1 = 16'h07E0;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        frame_clk = 1'b0;
    logic [2:0]  Game_State = 3'b000;
    logic [15:0] pos_x = '0;
    logic [15:0] pos_y = '0;
    logic [31:0] color = {C1, C0};
    logic [19:0] fb_addr;
    logic [15:0] fb_wdata;
    logic        fb_we, fb_re;
    logic        fb_ready = 1'b1;
    logic [15:0] fb_rdata;
    logic [1:0]  collision;
    logic        busy, done;

    trail_painter #(
        .NUM_PLAYERS(2), .COORD_W(8), .ADDR_W(20), .DATA_W(16), .BLK(2),
        .PITCH(320), .X_OFF(8), .RD_LAT(RD_LAT), .PLAY_STATE(PLAY)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .Game_State(Game_State),
        .pos_x(pos_x), .pos_y(pos_y), .color(color), .fb_addr(fb_addr),
        .fb_wdata(fb_wdata), .fb_we(fb_we), .fb_re(fb_re), .fb_ready(fb_ready),
        .fb_rdata(fb_rdata), .collision(collision), .busy(busy), .done(done)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Read-data model: value is valid only in the cycle it must be sampled, garbage otherwise.
    logic [19:0] hit_addr = 20'hFFFFF;
    logic [19:0] rd_addr_q = '0;
    int rd_age = 15;
    always @(posedge Clk) begin
        if (fb_re && fb_ready) begin
            rd_addr_q <= fb_addr;
            rd_age    <= 0;
        end else if (rd_age < 15) begin
            rd_age <= rd_age + 1;
        end
    end
    assign fb_rdata = (rd_age == RD_LAT - 1) ? ((rd_addr_q == hit_addr) ? 16'h0003 : 16'h0000)
                                             : 16'hBAD0;

    // Monitor: drives fb_ready at negedge and records accepted transactions.
    logic        ready_toggle = 1'b0;
    logic [19:0] rd_q[$];
    logic [19:0] wa_q[$];
    logic [15:0] wd_q[$];
    int busy_cyc = 0, done_cnt = 0, stalls = 0;
    logic stall_prev = 1'b0;
    logic [37:0] prev_bundle = '0;

    always @(negedge Clk) begin
        fb_ready = ready_toggle ? ~fb_ready : 1'b1;
        #1;
        if (fb_re || fb_we) begin
            n_checks++;
            if (fb_re && fb_we) begin
                n_err++;
                $display("FAIL re_we_excl: got re=%b we=%b required not both", fb_re, fb_we);
            end
        end
        if (stall_prev) begin
            n_checks++;
            if ({fb_re, fb_we, fb_addr, fb_wdata} !== prev_bundle) begin
                n_err++;
                $display("FAIL stall_hold: got %0h required %0h",
                         {fb_re, fb_we, fb_addr, fb_wdata}, prev_bundle);
            end
        end
        stall_prev  = (fb_re || fb_we) && !fb_ready;
        prev_bundle = {fb_re, fb_we, fb_addr, fb_wdata};
        if (busy) busy_cyc++;
        if (done) done_cnt++;
        if (stall_prev) stalls++;
        if (fb_re && fb_ready) rd_q.push_back(fb_addr);
        if (fb_we && fb_ready) begin
            wa_q.push_back(fb_addr);
            wd_q.push_back(fb_wdata);
        end
    end

    task automatic tick();
        @(negedge Clk);
        #2;
    endtask

    task automatic clear_log();
        rd_q.delete();
        wa_q.delete();
        wd_q.delete();
        busy_cyc = 0;
        done_cnt = 0;
        stalls   = 0;
    endtask

    task automatic reenter();
        Game_State = 3'b000;
        repeat (3) tick();
        Game_State = PLAY;
        repeat (2) tick();
    endtask

    task automatic pulse();
        frame_clk = 1'b1;
        tick();
        frame_clk = 1'b0;
        tick();
    endtask

    typedef struct {
        logic [7:0]       x0, y0, x1, y1;
        logic             re_enter, toggle;
        logic [19:0]      hit;
        int               nreads;
        logic [0:1][19:0] r;
        logic [0:7][19:0] w;
        int               cycles;
        logic [1:0]       coll;
    } vec_t;

    vec_t vecs [5];

    task automatic run_pass(input vec_t v);
        if (v.re_enter) reenter();
        pos_x        = {v.x1, v.x0};
        pos_y        = {v.y1, v.y0};
        hit_addr     = v.hit;
        ready_toggle = v.toggle;
        clear_log();
        pulse();
        for (int i = 0; i < 200 && !(done_cnt > 0 && !busy); i++) tick();
        repeat (3) tick();
        chk("done_count", done_cnt, 1);
        chk("nreads", rd_q.size(), v.nreads);
        for (int i = 0; i < v.nreads && i < rd_q.size(); i++) chk("read_addr", rd_q[i], v.r[i]);
        chk("nwrites", wa_q.size(), 8);
        for (int i = 0; i < 8 && i < wa_q.size(); i++) begin
            chk("write_addr", wa_q[i], v.w[i]);
            chk("write_data", wd_q[i], (i < 4) ? C0 : C1);
        end
        chk("pass_cycles", busy_cyc, v.cycles + stalls);
        chk("collision", collision, v.coll);
        ready_toggle = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish required finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{8'd10, 8'd3, 8'd0, 8'd0, 1'b1, 1'b0, 20'hFFFFF, 2, {20'd1956, 20'd16},
                    {20'd1956, 20'd1957, 20'd2276, 20'd2277, 20'd16, 20'd17, 20'd336, 20'd337},
                    17, 2'b00};
        vecs[1] = '{8'd10, 8'd3, 8'd0, 8'd0, 1'b0, 1'b0, 20'hFFFFF, 0, {20'd0, 20'd0},
                    {20'd1956, 20'd1957, 20'd2276, 20'd2277, 20'd16, 20'd17, 20'd336, 20'd337},
                    11, 2'b00};
        vecs[2] = '{8'd10, 8'd3, 8'd0, 8'd0, 1'b1, 1'b0, 20'd16, 2, {20'd1956, 20'd16},
                    {20'd1956, 20'd1957, 20'd2276, 20'd2277, 20'd16, 20'd17, 20'd336, 20'd337},
                    17, 2'b10};
        vecs[3] = '{8'd10, 8'd3, 8'd1, 8'd0, 1'b0, 1'b0, 20'hFFFFF, 1, {20'd18, 20'd0},
                    {20'd1956, 20'd1957, 20'd2276, 20'd2277, 20'd18, 20'd19, 20'd338, 20'd339},
                    14, 2'b10};
        vecs[4] = '{8'd10, 8'd3, 8'd0, 8'd0, 1'b1, 1'b1, 20'hFFFFF, 2, {20'd1956, 20'd16},
                    {20'd1956, 20'd1957, 20'd2276, 20'd2277, 20'd16, 20'd17, 20'd336, 20'd337},
                    17, 2'b00};

        // Reset values.
        repeat (2) tick();
        chk("rst_we", fb_we, 0);
        chk("rst_re", fb_re, 0);
        chk("rst_addr", fb_addr, 0);
        chk("rst_wdata", fb_wdata, 0);
        chk("rst_collision", collision, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        Reset_n = 1'b1;
        tick();
        Game_State = PLAY;
        repeat (2) tick();

        for (int i = 0; i < 5; i++) run_pass(vecs[i]);

        // Ticks during a pass: exactly one queued pass follows back to back.
        reenter();
        pos_x    = {8'd0, 8'd10};
        pos_y    = {8'd0, 8'd3};
        hit_addr = 20'hFFFFF;
        clear_log();
        pulse();
        repeat (3) tick();
        repeat (3) pulse();
        for (int i = 0; i < 80 && !(done_cnt > 1 && !busy); i++) tick();
        repeat (5) tick();
        chk("pend_done_count", done_cnt, 2);
        chk("pend_busy_cycles", busy_cyc, 28);
        chk("pend_nreads", rd_q.size(), 2);
        chk("pend_nwrites", wa_q.size(), 16);

        // Leave play mid-write: requests drop, collision holds, re-entry clears it.
        reenter();
        hit_addr = 20'd1956;
        clear_log();
        pulse();
        begin
            int n = 0;
            while (!fb_we && n < 50) begin
                tick();
                n++;
            end
            chk("abort_we_seen", fb_we, 1);
        end
        Game_State = 3'b000;
        tick();
        chk("abort_we", fb_we, 0);
        chk("abort_re", fb_re, 0);
        chk("abort_busy", busy, 0);
        chk("abort_coll_hold", collision, 2'b01);
        repeat (3) tick();
        chk("abort_no_done", done_cnt, 0);
        Game_State = PLAY;
        tick();
        chk("reenter_coll_clear", collision, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
